// File: rtl/sram_initiator_pkg.sv
// Shared definitions for the word-to-byte SRAM initiator: FSM encoding,
// word geometry and the byte-offset to data-lane mapping.
package sram_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  function automatic logic [1:0] lane_of(input logic [1:0] offset, input logic big_endian);
    return big_endian ? (2'd3 - offset) : offset;
  endfunction

endpackage

// File: rtl/sram_word_initiator.sv
// Turns one 32-bit word request into four sequential byte accesses on an
// 8-bit synchronous SRAM port with one-cycle read latency.
module sram_word_initiator
  import sram_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  requestValid,
  output logic                  requestReady,
  input  logic                  requestWrite,
  input  logic [ADDR_WIDTH-1:0] requestAddress,
  input  logic [31:0]           requestWriteData,
  input  logic [3:0]            requestByteEnables,
  output logic                  responseValid,
  output logic [31:0]           responseReadData,
  output logic                  sramWriteEnable,
  output logic [ADDR_WIDTH-1:0] sramAddress,
  output logic [7:0]            sramDataOut,
  input  logic [7:0]            sramDataIn
);

  localparam logic [1:0] LAST_OFFSET = 2'(BYTES_PER_WORD - 1);

  state_e                state_q;
  logic [1:0]            k_q;
  logic                  write_q;
  logic [ADDR_WIDTH-3:0] base_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic [31:0]           rdata_q;
  logic                  rvalid_q;
  logic                  ready_q;
  logic                  sram_we_q;
  logic [ADDR_WIDTH-1:0] sram_addr_q;
  logic [7:0]            sram_dout_q;

  logic                  accept;
  logic [1:0]            issue_off_d;
  logic [1:0]            issue_lane_d;
  logic [ADDR_WIDTH-3:0] issue_base_d;
  logic [31:0]           issue_word_d;
  logic [3:0]            issue_be_d;
  logic                  issue_wr_d;
  logic [7:0]            issue_byte_d;
  logic                  issue_we_d;
  logic [1:0]            cap_lane_d;
  logic                  unused_addr_lsbs;

  assign accept           = requestValid & ready_q;
  assign unused_addr_lsbs = ^requestAddress[1:0];

  // Offset 0 is issued on the accept edge straight from the request inputs,
  // later offsets come from the latched copy.
  always_comb begin
    issue_off_d  = accept ? 2'd0 : (k_q + 2'd1);
    issue_base_d = accept ? requestAddress[ADDR_WIDTH-1:2] : base_q;
    issue_word_d = accept ? requestWriteData : wdata_q;
    issue_be_d   = accept ? requestByteEnables : be_q;
    issue_wr_d   = accept ? requestWrite : write_q;
    issue_lane_d = lane_of(issue_off_d, BIG_ENDIAN);
    issue_byte_d = issue_word_d[{issue_lane_d, 3'b000} +: 8];
    issue_we_d   = issue_wr_d & issue_be_d[issue_lane_d];
    cap_lane_d   = lane_of((state_q == ST_DRAIN) ? LAST_OFFSET : (k_q - 2'd1), BIG_ENDIAN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      k_q         <= 2'd0;
      write_q     <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      ready_q     <= 1'b1;
      sram_we_q   <= 1'b0;
      sram_addr_q <= '0;
      sram_dout_q <= '0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            write_q     <= requestWrite;
            base_q      <= requestAddress[ADDR_WIDTH-1:2];
            wdata_q     <= requestWriteData;
            be_q        <= requestByteEnables;
            k_q         <= 2'd0;
            ready_q     <= 1'b0;
            state_q     <= ST_ACCESS;
            sram_addr_q <= {issue_base_d, issue_off_d};
            sram_dout_q <= issue_byte_d;
            sram_we_q   <= issue_we_d;
          end
        end
        ST_ACCESS: begin
          // Read byte k-1 returns while byte k is being addressed.
          if (!write_q && (k_q != 2'd0)) begin
            rdata_q[{cap_lane_d, 3'b000} +: 8] <= sramDataIn;
          end
          if (k_q == LAST_OFFSET) begin
            sram_we_q <= 1'b0;
            if (write_q) begin
              state_q  <= ST_DONE;
              rvalid_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else begin
            k_q         <= issue_off_d;
            sram_addr_q <= {issue_base_d, issue_off_d};
            sram_dout_q <= issue_byte_d;
            sram_we_q   <= issue_we_d;
          end
        end
        ST_DRAIN: begin
          rdata_q[{cap_lane_d, 3'b000} +: 8] <= sramDataIn;
          state_q  <= ST_DONE;
          rvalid_q <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign requestReady     = ready_q;
  assign responseValid    = rvalid_q;
  assign responseReadData = rdata_q;
  assign sramWriteEnable  = sram_we_q;
  assign sramAddress      = sram_addr_q;
  assign sramDataOut      = sram_dout_q;

endmodule
